crack_dispatch: RTL and testbench
=================================

// Module: crack_dispatch
// PURPOSE
// - Parametrised key-search dispatcher for the RC4 double-cracking design, generalised from 2 to NUM_CORES crack cores.
// - Hands candidate keys from [key_lo..key_hi] to whichever core is idle, one key per cycle, and collects pass/fail results.
// - The first reported match wins: all cores are aborted, and the winning key and core index are latched for pt_mem copy-out and HEX display.
// PARAMETERS
// - NUM_CORES  4   number of attached crack cores (1..16)
// - KEY_W      24  key width in bits
// - IDX_W      $clog2(NUM_CORES) (min 1)  width of the winner index
// PORTS
// - clk          in   1                   system clock
// - rst_n        in   1                   asynchronous, active-low reset
// - en           in   1                   start pulse; sampled only while rdy=1
// - key_lo       in   KEY_W               first key of the range; latched on en
// - key_hi       in   KEY_W               last key of the range, inclusive; latched on en
// - rdy          out  1                   idle/done; ready to accept en
// - key_valid    out  1                   last search found a key
// - key_out      out  KEY_W               winning key (0 if none found)
// - winner       out  IDX_W               index of the core that found the key
// - key_cur      out  KEY_W               next key to issue (progress display)
// - core_rdy     in   NUM_CORES           core i can accept a key
// - core_en      out  NUM_CORES           one-cycle pulse; at most one bit set per cycle
// - core_key     out  NUM_CORES*KEY_W     slice i is valid while core_en[i]=1
// - core_done    in   NUM_CORES           one-cycle pulse; core i finished its key
// - core_found   in   NUM_CORES           qualified by core_done[i]; ASCII check passed
// - core_abort   out  1                   one-cycle pulse to all cores; return to rdy
// BEHAVIOUR
// - Reset: state=IDLE; rdy=1; key_valid=0; key_out=0; winner=0; key_cur=0; core_en=0; core_abort=0; busy mask=0.
// - Reset is honoured mid-search with the same values. Cores are reset by the same rst_n.
// - State IDLE/DONE (rdy=1): en latches key_lo into the counter and key_hi; clears key_valid/key_out/winner; goes to RUN.
//   en is ignored while rdy=0.
// - State RUN, every cycle:
//   - Issue: pick the lowest i with core_rdy[i] & ~busy[i] while counter <= key_hi.
//     Pulse core_en[i] with core_key[i]=counter; set busy[i]; increment the counter.
//   - Retire: core_done[i] clears busy[i].
//   - Retire and issue to the same core in the same cycle is allowed.
//   - Counter is KEY_W+1 bits, so key_hi = all-ones terminates with no wrap.
//   - key_cur shows counter[KEY_W-1:0].
// - Found: any core_done[i] & core_found[i] in RUN:
//   - Winner is the lowest such i. Latch key_out=key in flight on core i, winner=i, key_valid=1.
//   - No core_en is issued in that cycle. Next cycle: core_abort=1 for 1 cycle, busy cleared, go to DONE.
//   - Latency: found -> rdy=1 is 2 cycles.
// - Exhaustion: counter > key_hi and busy==0 with no found -> DONE with key_valid=0, key_out=0.
// - key_hi < key_lo at en: RUN issues nothing; DONE next cycle with key_valid=0.
// - core_done arriving in DONE/IDLE, or for a core not busy, is ignored.
// - Per-core in-flight key is held in a register array, NUM_CORES x KEY_W.
// STRUCTURE
// - crack_pkg:
//   - typedef enum logic [1:0] {S_IDLE, S_RUN, S_ABORT, S_DONE} disp_state_t
//   - localparam MAX_CORES=16
// - Sub-module lowest_set #(N): one-hot and index of the lowest set bit, plus any.
//   Instantiated twice, for idle-core select and found arbitration.
// - One always_ff for the FSM/counter, one for the inflight/busy registers; issue logic is combinational.
// TESTING (behavioural core models, configurable latency, match on a chosen key)
// 1. NUM_CORES=4, range 0..15, match at 0x00000B, latency 5:
//    -> key_valid=1, key_out=0x00000B, core_abort pulsed once, no core_en after the found cycle.
// 2. Range 0..7, no match:
//    -> each key issued exactly once (scoreboard), rdy=1 only after the last core_done, key_valid=0, key_out=0.
// 3. Cores 1 and 3 report found in the same cycle (keys 0x21, 0x23):
//    -> winner=1, key_out=0x21.
// 4. key_lo=key_hi=0xFFFFFF, match:
//    -> one issue, found, no wrap. key_hi=0xFFFFFE, key_lo=0xFFFFFF -> DONE in 2 cycles, key_valid=0.
// 5. Assert rst_n low mid-RUN, then restart with en on range 0x10..0x1F, match at 0x18:
//    -> outputs at reset values while low, then key_out=0x18. en while rdy=0 has no effect.
// 6. Core 2 held with core_rdy=0 throughout:
//    -> core_en[2] never asserted, search still completes.

Source files
------------

// File: rtl/crack_pkg.sv
// crack_pkg: shared dispatcher state encoding and core-count limit
package crack_pkg;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_ABORT, S_DONE} disp_state_t;
    localparam int MAX_CORES = 16;
endpackage

// File: rtl/lowest_set.sv
// lowest_set: one-hot mask and index of the lowest set bit, plus any-set flag
module lowest_set #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  v,
    output logic [N-1:0]  oh,
    output logic [IW-1:0] idx,
    output logic          any
);
    assign oh  = v & (~v + N'(1));
    assign any = |v;
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--)
            if (v[i]) idx = IW'(i);
    end
endmodule

// File: rtl/crack_dispatch.sv
// crack_dispatch: hands keys from [key_lo..key_hi] to idle crack cores, one per cycle,
// and latches the first reported match before aborting every core.
module crack_dispatch
    import crack_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int KEY_W     = 24,
    parameter int IDX_W     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic [KEY_W-1:0]           key_lo,
    input  logic [KEY_W-1:0]           key_hi,
    output logic                       rdy,
    output logic                       key_valid,
    output logic [KEY_W-1:0]           key_out,
    output logic [IDX_W-1:0]           winner,
    output logic [KEY_W-1:0]           key_cur,
    input  logic [NUM_CORES-1:0]       core_rdy,
    output logic [NUM_CORES-1:0]       core_en,
    output logic [NUM_CORES*KEY_W-1:0] core_key,
    input  logic [NUM_CORES-1:0]       core_done,
    input  logic [NUM_CORES-1:0]       core_found,
    output logic                       core_abort
);
    disp_state_t          state;
    logic [KEY_W:0]       cnt;
    logic [KEY_W-1:0]     hi;
    logic [NUM_CORES-1:0] busy, avail, hits, idle_oh, unused_hit_oh;
    logic [IDX_W-1:0]     idle_idx, hit_idx;
    logic                 idle_any, hit_any, more, issue_ok;
    logic [KEY_W-1:0]     inflight [NUM_CORES];

    // a core finishing this cycle may take the next key immediately
    assign avail    = core_rdy & (~busy | core_done);
    assign hits     = core_done & core_found & busy;
    assign more     = cnt <= {1'b0, hi};
    assign issue_ok = state == S_RUN && more && idle_any && !hit_any;
    assign core_en  = issue_ok ? idle_oh : '0;
    assign core_key = {NUM_CORES{cnt[KEY_W-1:0]}};
    assign key_cur  = cnt[KEY_W-1:0];
    assign rdy      = state == S_IDLE || state == S_DONE;

    lowest_set #(.N(NUM_CORES), .IW(IDX_W)) u_idle (
        .v(avail), .oh(idle_oh), .idx(idle_idx), .any(idle_any)
    );
    lowest_set #(.N(NUM_CORES), .IW(IDX_W)) u_hit (
        .v(hits), .oh(unused_hit_oh), .idx(hit_idx), .any(hit_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            hi         <= '0;
            key_valid  <= 1'b0;
            key_out    <= '0;
            winner     <= '0;
            core_abort <= 1'b0;
        end else begin
            core_abort <= 1'b0;
            case (state)
                S_IDLE, S_DONE: if (en) begin
                    state     <= S_RUN;
                    cnt       <= {1'b0, key_lo};
                    hi        <= key_hi;
                    key_valid <= 1'b0;
                    key_out   <= '0;
                    winner    <= '0;
                end
                S_RUN: if (hit_any) begin
                    state      <= S_ABORT;
                    core_abort <= 1'b1;
                    key_valid  <= 1'b1;
                    key_out    <= inflight[hit_idx];
                    winner     <= hit_idx;
                end else begin
                    if (issue_ok) cnt <= cnt + (KEY_W+1)'(1);
                    if (!more && busy == '0) state <= S_DONE;
                end
                default: state <= S_DONE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
            for (int i = 0; i < NUM_CORES; i++) inflight[i] <= '0;
        end else begin
            busy <= (state == S_RUN) ? (busy & ~core_done) | core_en : '0;
            if (issue_ok) inflight[idle_idx] <= cnt[KEY_W-1:0];
        end
    end
endmodule

// File: tb/tb_crack_dispatch.sv
// tb_crack_dispatch: behavioural crack cores with per-core latency drive the dispatcher;
// results are checked against range/match rules and an issue-order scoreboard.
module tb_crack_dispatch;
    localparam int NC = 4;
    localparam int KW = 24;

    logic              clk = 1'b0, rst_n = 1'b0, en = 1'b0;
    logic [KW-1:0]     key_lo = '0, key_hi = '0, key_out, key_cur;
    logic              rdy, key_valid, core_abort;
    logic [1:0]        winner;
    logic [NC-1:0]     core_rdy = '0, core_en, core_done = '0, core_found = '0;
    logic [NC*KW-1:0]  core_key;

    int checks = 0, passed = 0;

    logic [NC-1:0] cb = '0, mask = '1;
    int            ct [NC];
    logic [KW-1:0] ck [NC];
    int            lat [NC];
    logic [KW-1:0] m0 = '0, m1 = '0, exp_next = '0, key_exp = '0;
    bit            m0_en = 0, m1_en = 0, found_flag = 0, rdy_seen = 0;
    int            cyc = 0, found_cyc = 0, win_exp = 0, n_issued = 0, abort_cnt = 0;

    crack_dispatch #(.NUM_CORES(NC), .KEY_W(KW)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .key_lo(key_lo), .key_hi(key_hi),
        .rdy(rdy), .key_valid(key_valid), .key_out(key_out), .winner(winner),
        .key_cur(key_cur), .core_rdy(core_rdy), .core_en(core_en), .core_key(core_key),
        .core_done(core_done), .core_found(core_found), .core_abort(core_abort)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // core models plus issue scoreboard; inputs for the next edge are driven here
    always @(negedge clk) begin
        logic [NC-1:0] dn, fd, spur;
        logic [KW-1:0] k;
        int w;
        cyc++;
        k = '0;
        spur = NC'($urandom) & NC'($urandom) & ~cb;
        for (int i = 0; i < NC; i++) begin
            dn[i] = cb[i] && ct[i] == 0;
            fd[i] = dn[i] && ((m0_en && ck[i] == m0) || (m1_en && ck[i] == m1));
        end
        core_done  = dn | spur;
        core_found = fd | (~dn & NC'($urandom));
        core_rdy   = mask & (~cb | dn);
        if (fd != '0 && !found_flag) begin
            found_flag = 1;
            found_cyc  = cyc;
            w = 0;
            for (int i = NC - 1; i >= 0; i--) if (fd[i]) w = i;
            win_exp = w;
            key_exp = ck[w];
        end
        #1;
        if (!rst_n) cb = '0;
        else begin
            if (core_en != '0) begin
                w = 0;
                for (int i = 0; i < NC; i++) if (core_en[i]) w = i;
                k = core_key[w*KW +: KW];
                chk("en_onehot", $countones(core_en), 1);
                chk("en_masked_core", 32'(core_en & ~mask), 0);
                chk("en_after_found", 32'(found_flag), 0);
                chk("issue_order", k, exp_next);
                exp_next++;
                n_issued++;
            end
            if (core_abort) abort_cnt++;
            if (found_flag && rdy && !rdy_seen) begin
                rdy_seen = 1;
                chk("found_to_rdy", cyc - found_cyc, 2);
            end
            for (int i = 0; i < NC; i++) begin
                if (core_abort || dn[i]) cb[i] = 1'b0;
                else if (cb[i]) ct[i]--;
                if (core_en[i]) begin
                    cb[i] = 1'b1;
                    ct[i] = lat[i] - 1;
                    ck[i] = k;
                end
            end
        end
    end

    task automatic search(input logic [KW-1:0] lo, input logic [KW-1:0] hi, input bit poke, output int n);
        @(negedge clk);
        found_flag = 0; rdy_seen = 0; exp_next = lo; n_issued = 0; abort_cnt = 0;
        key_lo = lo; key_hi = hi; en = 1;
        @(negedge clk);
        en = 0;
        n = 1;
        while (!rdy && n < 4000) begin
            if (poke && n == 3) begin
                en = 1; key_lo = '0; key_hi = 24'h3;
            end else en = 0;
            @(negedge clk);
            n++;
        end
        en = 0;
        chk("search_completes", 32'(rdy), 1);
        chk("cores_idle_at_rdy", 32'(cb), 0);
    endtask

    initial begin
        int n;
        logic [KW-1:0] lo, hi;
        bit v;
        lat = '{5, 5, 5, 5};
        repeat (3) @(negedge clk);
        chk("reset_rdy", 32'(rdy), 1);
        chk("reset_key_valid", 32'(key_valid), 0);
        chk("reset_key_out", key_out, 0);
        chk("reset_winner", winner, 0);
        chk("reset_key_cur", key_cur, 0);
        chk("reset_core_en", 32'(core_en), 0);
        chk("reset_core_abort", 32'(core_abort), 0);
        rst_n = 1;

        m0 = 24'h00000B; m0_en = 1;
        search(24'h0, 24'hF, 0, n);
        chk("t1_valid", 32'(key_valid), 1);
        chk("t1_key", key_out, 24'hB);
        chk("t1_winner", winner, win_exp);
        chk("t1_abort_pulses", abort_cnt, 1);

        m0_en = 0;
        search(24'h0, 24'h7, 0, n);
        chk("t2_issued", n_issued, 8);
        chk("t2_valid", 32'(key_valid), 0);
        chk("t2_key", key_out, 0);
        chk("t2_abort_pulses", abort_cnt, 0);

        lat = '{6, 6, 6, 4};
        m0 = 24'h21; m1 = 24'h23; m0_en = 1; m1_en = 1;
        search(24'h20, 24'h23, 0, n);
        chk("t3_valid", 32'(key_valid), 1);
        chk("t3_winner", winner, 1);
        chk("t3_key", key_out, 24'h21);
        lat = '{5, 5, 5, 5}; m1_en = 0;

        m0 = 24'hFFFFFF;
        search(24'hFFFFFF, 24'hFFFFFF, 0, n);
        chk("t4_issued", n_issued, 1);
        chk("t4_valid", 32'(key_valid), 1);
        chk("t4_key", key_out, 24'hFFFFFF);
        chk("t4_key_cur", key_cur, 0);
        m0_en = 0;
        search(24'hFFFFFF, 24'hFFFFFE, 0, n);
        chk("t4_empty_cycles", n, 2);
        chk("t4_empty_issued", n_issued, 0);
        chk("t4_empty_valid", 32'(key_valid), 0);
        search(24'hFFFFFE, 24'hFFFFFF, 0, n);
        chk("t4_top_issued", n_issued, 2);
        chk("t4_top_valid", 32'(key_valid), 0);

        @(negedge clk);
        found_flag = 0; exp_next = '0; n_issued = 0;
        key_lo = '0; key_hi = 24'hFFFF; en = 1;
        @(negedge clk);
        en = 0;
        repeat (6) @(negedge clk);
        rst_n = 0;
        #2;
        chk("midrst_rdy", 32'(rdy), 1);
        chk("midrst_key_valid", 32'(key_valid), 0);
        chk("midrst_key_out", key_out, 0);
        chk("midrst_winner", winner, 0);
        chk("midrst_key_cur", key_cur, 0);
        chk("midrst_core_en", 32'(core_en), 0);
        chk("midrst_core_abort", 32'(core_abort), 0);
        @(negedge clk);
        chk("midrst_hold_key_cur", key_cur, 0);
        rst_n = 1;
        m0 = 24'h18; m0_en = 1;
        search(24'h10, 24'h1F, 1, n);
        chk("t5_valid", 32'(key_valid), 1);
        chk("t5_key", key_out, 24'h18);

        mask = 4'b1011; m0_en = 0;
        search(24'h40, 24'h5F, 0, n);
        chk("t6_issued", n_issued, 32);
        chk("t6_valid", 32'(key_valid), 0);

        for (int t = 0; t < 6; t++) begin
            foreach (lat[i]) lat[i] = $urandom_range(1, 7);
            mask = NC'($urandom_range(1, 15));
            lo = KW'($urandom_range(1, 2000));
            hi = (t == 5) ? lo - 24'd1 : lo + KW'($urandom_range(0, 40));
            m0 = lo + KW'($urandom_range(0, 50)) - 24'd5;
            m0_en = 1;
            v = m0 >= lo && m0 <= hi;
            search(lo, hi, 0, n);
            chk("rnd_valid", 32'(key_valid), 32'(v));
            chk("rnd_key", key_out, v ? m0 : 24'h0);
            chk("rnd_abort_pulses", abort_cnt, 32'(v));
            if (v) chk("rnd_winner", winner, win_exp);
            else chk("rnd_issued", n_issued, (hi >= lo) ? 32'(hi - lo) + 1 : 0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
